ysyx_lsu: RTL and testbench

- Multi-cycle load/store unit; replaces the single-cycle, zero-latency data-memory path of the execute stage.
- Accepts one memory op per handshake from EXU and issues one aligned bus request with byte mask.
- Waits for the bus response, then returns formatted load data: byte-lane extract plus sign/zero extension.
- Parametrised in data width (32/64) and address width; flags misaligned/illegal accesses instead of issuing them.

---
 rtl/ysyx_lsu.sv | 218 +++++++++++++++++++++
 tb/tb_ysyx_lsu.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_lsu.sv
// ysyx_lsu: multi-cycle load/store unit between the execute stage and a simple
// request/response data bus. Takes one op per in_valid/in_ready handshake,
// issues a single aligned bus request with byte mask, waits for the response
// and returns byte-lane extracted, sign/zero-extended load data.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready     op handshake from EXU
//   in_addr, in_wdata     byte address, right-aligned store data
//   in_store, in_size     1 = store; size 0/1/2/3 = B/H/W/D
//   in_unsigned           zero-extend load when 1
//   out_valid/out_ready   result handshake to EXU/WB
//   out_rdata, out_fault  formatted load data (0 for stores/faults), fault flag
//   mem_req_*             registered bus request (addr aligned, wen, wdata, wmask)
//   mem_rsp_valid/rdata   bus response; ignored outside RESP
//
// Optional: define LSU_TIMEOUT_EN to abort a request/response wait after
// TIMEOUT_CYCLES cycles with out_fault = 1.
//
// state | meaning
// IDLE  | ready for a new op
// REQ   | bus request presented, waiting for mem_req_ready
// RESP  | request accepted, waiting for mem_rsp_valid
// DONE  | result presented, waiting for out_ready

module ysyx_lsu #(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [XLEN-1:0]     in_wdata,
    input  logic                in_store,
    input  logic [1:0]          in_size,
    input  logic                in_unsigned,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_rdata,
    output logic                out_fault,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [XLEN-1:0]     mem_req_wdata,
    output logic [XLEN/8-1:0]   mem_req_wmask,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rsp_rdata
);

    localparam int BYTES = XLEN / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int SH_W  = OFF_W + 3;

    if (TIMEOUT_CYCLES < 1 || (XLEN != 32 && XLEN != 64)) begin : g_bad_param
        $error("ysyx_lsu: XLEN must be 32 or 64 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic                req_wen_q, req_wen_d;
    logic [XLEN-1:0]     req_wdata_q, req_wdata_d;
    logic [BYTES-1:0]    req_wmask_q, req_wmask_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [1:0]          size_q, size_d;
    logic                unsigned_q, unsigned_d;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic                fault_q, fault_d;

    // Accept-side decode
    logic [2:0]          addr_lo;
    logic [2:0]          align_mask;
    logic                in_fault;
    logic [OFF_W-1:0]    in_off;
    logic [15:0]         size_bytes_mask;
    logic [BYTES-1:0]    base_mask;

    assign addr_lo         = in_addr[2:0];
    assign align_mask      = (3'd1 << in_size) - 3'd1;
    assign in_fault        = ((addr_lo & align_mask) != 3'd0) || (in_size == 2'd3 && XLEN == 32);
    assign in_off          = in_addr[OFF_W-1:0];
    assign size_bytes_mask = (16'd1 << (5'd1 << in_size)) - 16'd1;
    assign base_mask       = size_bytes_mask[BYTES-1:0];

    // Load lane extraction. keep covers the 2^size low bytes; its top set bit
    // is the sign bit. Shifts that overflow XLEN wrap keep to all ones.
    logic [XLEN-1:0]     lane, keep, keep_top, ext;
    logic [6:0]          nbits;
    logic                sign;

    assign lane     = mem_rsp_rdata >> {off_q, 3'b000};
    assign nbits    = 7'd8 << size_q;
    assign keep     = (XLEN'(1) << nbits) - XLEN'(1);
    assign keep_top = keep & ~(keep >> 1);
    assign sign     = ~unsigned_q & (|(lane & keep_top));
    assign ext      = (lane & keep) | ({XLEN{sign}} & ~keep);

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    wait_q, wait_d;
    logic                timeout;
`endif

    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        req_wen_d   = req_wen_q;
        req_wdata_d = req_wdata_q;
        req_wmask_d = req_wmask_q;
        off_d       = off_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        rdata_d     = rdata_q;
        fault_d     = fault_q;
`ifdef LSU_TIMEOUT_EN
        wait_d      = wait_q;
        timeout     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    req_addr_d  = in_addr & ~ADDR_W'(BYTES - 1);
                    req_wen_d   = in_store;
                    req_wdata_d = in_store ? (in_wdata << {in_off, 3'b000}) : '0;
                    req_wmask_d = in_store ? (base_mask << in_off) : '0;
                    off_d       = in_off;
                    size_d      = in_size;
                    unsigned_d  = in_unsigned;
                    rdata_d     = '0;
                    fault_d     = in_fault;
                    state_d     = in_fault ? S_DONE : S_REQ;
`ifdef LSU_TIMEOUT_EN
                    wait_d      = '0;
`endif
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (mem_rsp_valid) begin
                    state_d = S_DONE;
                    if (!req_wen_q) begin
                        rdata_d = ext;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef LSU_TIMEOUT_EN
        if (state_q == S_REQ || state_q == S_RESP) begin
            wait_d  = wait_q + 1'b1;
            timeout = (wait_q == CNT_W'(TIMEOUT_CYCLES - 1));
            // A response landing on the last cycle still completes normally.
            if (timeout && !(state_q == S_RESP && mem_rsp_valid)) begin
                state_d = S_DONE;
                fault_d = 1'b1;
                rdata_d = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_addr_q  <= '0;
            req_wen_q   <= 1'b0;
            req_wdata_q <= '0;
            req_wmask_q <= '0;
            off_q       <= '0;
            size_q      <= '0;
            unsigned_q  <= 1'b0;
            rdata_q     <= '0;
            fault_q     <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            wait_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_wen_q   <= req_wen_d;
            req_wdata_q <= req_wdata_d;
            req_wmask_q <= req_wmask_d;
            off_q       <= off_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
`ifdef LSU_TIMEOUT_EN
            wait_q      <= wait_d;
`endif
        end
    end

    assign in_ready      = (state_q == S_IDLE);
    assign out_valid     = (state_q == S_DONE);
    assign out_rdata     = rdata_q;
    assign out_fault     = fault_q;
    assign mem_req_valid = (state_q == S_REQ);
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wen   = req_wen_q;
    assign mem_req_wdata = req_wdata_q;
    assign mem_req_wmask = req_wmask_q;

endmodule

// File: tb/tb_ysyx_lsu.sv
module tb_ysyx_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_ready, in_store, in_unsigned;
    logic [31:0] in_addr, in_wdata;
    logic [1:0]  in_size;
    logic        out_valid, out_ready, out_fault;
    logic [31:0] out_rdata;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    ysyx_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_store(in_store), .in_size(in_size), .in_unsigned(in_unsigned),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_fault(out_fault),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        fault;
    } out_t;

    req_t        exp_req[$];
    out_t        exp_out[$];
    logic [31:0] rsp_q[$];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   hs_cnt  = 0;
    logic bp_mode = 1'b0;
    logic drop_rsp = 1'b0;
    logic force_rsp = 1'b0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic on byte counts and offsets.
    function automatic void model(input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] word, input logic st, input logic [1:0] sz,
                                  input logic uns, output req_t rq, output out_t ro);
        int     nbytes;
        int     off;
        longint v;
        logic   flt;
        nbytes = 1 << sz;
        off    = int'(addr % 4);
        flt    = (sz == 2'd3) || ((addr % nbytes) != 0);
        rq.addr  = addr - off;
        rq.wen   = st;
        rq.wmask = st ? 4'(((1 << nbytes) - 1) << off) : 4'd0;
        rq.wdata = st ? 32'(longint'(wdata) << (8 * off)) : 32'd0;
        v = (longint'(word) >> (8 * off)) & ((longint'(1) << (8 * nbytes)) - 1);
        if (!uns && v >= (longint'(1) << (8 * nbytes - 1)))
            v = v - (longint'(1) << (8 * nbytes));
        ro.rdata = (st || flt) ? 32'd0 : 32'(v);
        ro.fault = flt;
    endfunction

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
    endtask

    task automatic drive(input logic [31:0] addr, input logic [31:0] wdata, input logic st,
                         input logic [1:0] sz, input logic uns);
        in_valid = 1'b1; in_addr = addr; in_wdata = wdata;
        in_store = st; in_size = sz; in_unsigned = uns;
        @(posedge clk); #1;
        in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom;
        in_store = 1'($urandom); in_size = 2'($urandom); in_unsigned = 1'($urandom);
    endtask

    task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic st,
                         input logic [1:0] sz, input logic uns, input logic [31:0] word);
        req_t rq;
        out_t ro;
        model(addr, wdata, word, st, sz, uns, rq, ro);
        wait_ready();
        if (!ro.fault) begin
            exp_req.push_back(rq);
            rsp_q.push_back(word);
        end
        exp_out.push_back(ro);
        drive(addr, wdata, st, sz, uns);
        @(negedge clk);
        if (ro.fault) check("fault_latency", {out_valid, mem_req_valid}, 2'b10);
        else          check("req_latency", mem_req_valid, 1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_out.size() != 0 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain", exp_out.size(), 0);
    endtask

    // Bus model: random request backpressure, delayed responses, and stray
    // response pulses whenever no response is legitimately expected.
    initial begin
        logic        hs;
        logic        armed = 1'b0;
        int          dly = 0;
        int          stall_n = 0;
        logic [31:0] word = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
        forever begin
            @(negedge clk);
            hs = mem_req_valid && mem_req_ready && !rst;
            @(posedge clk); #1;
            if (rst) armed = 1'b0;
            mem_rsp_valid = 1'b0;
            mem_rsp_rdata = $urandom;
            if (hs && !drop_rsp) begin
                armed = 1'b1;
                dly   = $urandom_range(0, 3);
                word  = (rsp_q.size() != 0) ? rsp_q.pop_front() : 32'd0;
            end
            if (force_rsp) begin
                mem_rsp_valid = 1'b1;
            end else if (armed) begin
                if (dly == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_rdata = word;
                    armed = 1'b0;
                end else begin
                    dly--;
                end
            end else if (!drop_rsp && !mem_req_valid && $urandom_range(0, 3) == 0) begin
                mem_rsp_valid = 1'b1;
            end
            if (!mem_req_valid) stall_n = 0;
            if (bp_mode && mem_req_valid && stall_n < 5) begin
                mem_req_ready = 1'b0;
                stall_n++;
            end else begin
                mem_req_ready = bp_mode || ($urandom_range(0, 2) != 0);
            end
        end
    end

    // Result sink with random or directed backpressure.
    initial begin
        int ostall = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!out_valid) ostall = 0;
            if (bp_mode && out_valid && ostall < 3) begin
                out_ready = 1'b0;
                ostall++;
            end else begin
                out_ready = bp_mode || ($urandom_range(0, 2) != 0);
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic        req_stall = 1'b0;
        logic        out_stall = 1'b0;
        logic [69:0] saved_req = '0;
        logic [33:0] saved_out = '0;
        req_t        rq;
        out_t        ro;
        forever begin
            @(negedge clk);
            if (rst) begin
                req_stall = 1'b0;
                out_stall = 1'b0;
            end else begin
                if (req_stall)
                    check("req_hold", {mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask}, saved_req);
                if (out_stall)
                    check("out_hold", {out_valid, out_rdata, out_fault}, saved_out);
                if (mem_req_valid || out_valid)
                    check("in_ready_busy", in_ready, 0);
                if (mem_req_valid && mem_req_ready) begin
                    hs_cnt++;
                    if (exp_req.size() == 0) begin
                        check("req_unexpected", mem_req_valid, 0);
                    end else begin
                        rq = exp_req.pop_front();
                        check("req_fields", {mem_req_addr, mem_req_wen, mem_req_wmask}, {rq.addr, rq.wen, rq.wmask});
                        if (rq.wen) check("req_wdata", mem_req_wdata, rq.wdata);
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_out.size() == 0) begin
                        check("out_unexpected", out_valid, 0);
                    end else begin
                        ro = exp_out.pop_front();
                        check("out_result", {out_rdata, out_fault}, {ro.rdata, ro.fault});
                    end
                end
                req_stall = mem_req_valid && !mem_req_ready;
                saved_req = {mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask};
                out_stall = out_valid && !out_ready;
                saved_out = {out_valid, out_rdata, out_fault};
            end
        end
    end

    initial begin
        req_t rq;
        out_t ro;
        int   start;
        int   t;
        in_valid = 1'b0; in_addr = '0; in_wdata = '0;
        in_store = 1'b0; in_size = '0; in_unsigned = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_state",
              {in_ready, out_valid, out_rdata, out_fault, mem_req_valid, mem_req_addr,
               mem_req_wen, mem_req_wdata, mem_req_wmask},
              {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0});
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        issue(32'h8000_0003, 32'h0, 1'b0, 2'd0, 1'b0, 32'h8A12_3456);   // LB
        issue(32'h8000_0002, 32'h0, 1'b0, 2'd1, 1'b1, 32'hBEEF_1234);   // LHU
        issue(32'h8000_0002, 32'h0, 1'b0, 2'd1, 1'b0, 32'hBEEF_1234);   // LH
        issue(32'h8000_0002, 32'h0000_1234, 1'b1, 2'd1, 1'b0, 32'h0);   // SH
        issue(32'h8000_0001, 32'h0, 1'b0, 2'd2, 1'b0, 32'h0);           // LW misaligned
        issue(32'h8000_0000, 32'h0, 1'b0, 2'd3, 1'b0, 32'h0);           // LD on 32-bit
        issue(32'h8000_0004, 32'hCAFE_F00D, 1'b1, 2'd2, 1'b0, 32'h0);   // SW
        issue(32'h8000_0001, 32'h0000_00A5, 1'b1, 2'd0, 1'b0, 32'h0);   // SB lane 1
        drain();

        // Backpressure: request stalled 5 cycles, result stalled 3 cycles
        bp_mode = 1'b1;
        issue(32'h8000_0010, 32'h0, 1'b0, 2'd2, 1'b0, 32'h1357_9BDF);
        issue(32'h8000_0016, 32'h0000_8001, 1'b1, 2'd1, 1'b0, 32'h0);
        drain();
        bp_mode = 1'b0;

        // Reset while waiting for a response, then a late response pulse
        drop_rsp = 1'b1;
        wait_ready();
        model(32'h8000_0020, 32'h0, 32'h0, 1'b0, 2'd2, 1'b0, rq, ro);
        exp_req.push_back(rq);
        start = hs_cnt;
        drive(32'h8000_0020, 32'h0, 1'b0, 2'd2, 1'b0);
        t = 0;
        while (hs_cnt == start && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("rst_req_handshake", hs_cnt - start, 1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("rst_abort", {in_ready, out_valid, mem_req_valid, out_fault}, 4'b1000);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        force_rsp = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        force_rsp = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("late_rsp_ignored", {in_ready, out_valid, mem_req_valid}, 3'b100);
        end
        drop_rsp = 1'b0;
        @(posedge clk); #1;

        // Randomised ops
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            a  = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            issue(a, $urandom, 1'($urandom), sz, 1'($urandom), $urandom);
        end
        drain();

`ifdef LSU_TIMEOUT_EN
        drop_rsp = 1'b1;
        wait_ready();
        model(32'h8000_0040, 32'h0, 32'h0, 1'b0, 2'd2, 1'b0, rq, ro);
        exp_req.push_back(rq);
        ro.rdata = 32'd0;
        ro.fault = 1'b1;
        exp_out.push_back(ro);
        drive(32'h8000_0040, 32'h0, 1'b0, 2'd2, 1'b0);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 50);
        check("timeout_latency", t, 9);
        @(posedge clk); #1;
        drain();
        drop_rsp = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
